// File: rtl/buffer_pool_pingpong.sv
// Ping/pong buffer pool between the DMA loader and the MAC mesh.
// Each lane owns a two-bank RAM; a producer fills one bank while the mesh
// drains the other, and the banks swap under a fill/drain handshake.

// One lane: write-stage register, two-bank RAM, registered read port.
module buffer_pool_lane #(
  parameter int ADDR_LEN = 13,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                wbank,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic [DATA_LEN-1:0] wdata,
  input  logic                re,
  input  logic                rbank,
  input  logic [ADDR_LEN-1:0] raddr,
  output logic [DATA_LEN-1:0] rdata
);
  logic [DATA_LEN-1:0] mem [2**(ADDR_LEN+1)];
  logic                we_q;
  logic [ADDR_LEN:0]   wa_q;
  logic [DATA_LEN-1:0] wd_q;

  // W1 stage: hold the gated write together with the bank it was aimed at
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we;
      wa_q <= {wbank, waddr};
      wd_q <= wdata;
    end
  end

  // RAM body: commit the W1 write, registered read (contents never reset)
  always_ff @(posedge clk) begin
    if (we_q) mem[wa_q] <= wd_q;
    if (re)   rdata <= mem[{rbank, raddr}];
  end
endmodule

module buffer_pool_pingpong #(
  parameter int X_MAC      = 4,
  parameter int X_MESH     = 16,
  parameter int ADDR_LEN   = 13,
  parameter int DATA_LEN   = 32,
  parameter int BUFFER_NUM = X_MAC * X_MESH,
  parameter int DATAWIDTH  = BUFFER_NUM * DATA_LEN,
  parameter int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATAWIDTH-1:0]  dina,
  input  logic [ADDRWIDTH-1:0]  addra,
  input  logic [BUFFER_NUM-1:0] wea,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic [ADDRWIDTH-1:0]  addrb,
  input  logic                  rd_en,
  input  logic                  rd_done,
  output logic                  rd_ready,
  output logic [DATAWIDTH-1:0]  doutb,
  output logic                  doutb_valid,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic                  wr_err
);
  logic [1:0]                          full, full_nxt;
  logic                                wr_go, rd_go, rd_req;
  logic [2:1]                          vld_pipe;
  logic [BUFFER_NUM-1:0][DATA_LEN-1:0] ram_q;

  assign wr_ready    = ~full[wr_bank];
  assign rd_ready    = full[rd_bank];
  assign wr_go       = wr_done & wr_ready;
  assign rd_go       = rd_done & rd_ready;
  assign rd_req      = rd_en & rd_ready;
  assign doutb_valid = vld_pipe[2];

  // Fill marks the write bank full, drain empties the read bank; a fill
  // needs an empty bank and a drain a full one, so they never collide.
  always_comb begin
    full_nxt = full;
    if (wr_go) full_nxt[wr_bank] = 1'b1;
    if (rd_go) full_nxt[rd_bank] = 1'b0;
  end

  // Bank flags, pointers and the sticky write-while-blocked error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_go) wr_bank <= ~wr_bank;
      if (rd_go) rd_bank <= ~rd_bank;
      if (!wr_ready && (|wea || wr_done)) wr_err <= 1'b1;
    end
  end

  // Read valid shift register and output register; doutb holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      doutb    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd_req};
      if (vld_pipe[1]) doutb <= ram_q;
    end
  end

  for (genvar i = 0; i < BUFFER_NUM; i++) begin : g_lane
    buffer_pool_lane #(
      .ADDR_LEN(ADDR_LEN),
      .DATA_LEN(DATA_LEN)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wea[i] & wr_ready),
      .wbank (wr_bank),
      .waddr (addra[i*ADDR_LEN +: ADDR_LEN]),
      .wdata (dina[i*DATA_LEN +: DATA_LEN]),
      .re    (rd_req),
      .rbank (rd_bank),
      .raddr (addrb[i*ADDR_LEN +: ADDR_LEN]),
      .rdata (ram_q[i])
    );
  end
endmodule

// File: tb/tb_buffer_pool_pingpong.sv
// Randomised bench for buffer_pool_pingpong against a bank/queue level model.
module tb_buffer_pool_pingpong;
  localparam int AL = 4, DL = 32, NL = 64, DEPTH = 16;
  localparam int DW = NL * DL, AW = NL * AL;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] dina = '0, doutb;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [NL-1:0] wea = '0;
  logic          wr_done = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
  logic          wr_ready, rd_ready, doutb_valid, wr_bank, rd_bank, wr_err;

  buffer_pool_pingpong #(.X_MAC(4), .X_MESH(16), .ADDR_LEN(AL), .DATA_LEN(DL)) dut (
    .clk(clk), .rst_n(rst_n), .dina(dina), .addra(addra), .wea(wea),
    .wr_done(wr_done), .wr_ready(wr_ready), .addrb(addrb), .rd_en(rd_en),
    .rd_done(rd_done), .rd_ready(rd_ready), .doutb(doutb), .doutb_valid(doutb_valid),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // model state
  logic [DL-1:0] mem_m [2][NL][DEPTH];
  bit [1:0]      full_m;
  bit            wb_m, rb_m, err_m, exp_valid;
  logic [DW-1:0] exp_q[$];
  int            due_q[$];
  logic [DW-1:0] dout_m;
  bit [NL-1:0]   p_we;
  bit            p_bank;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;

  function automatic int diff_lane(logic [DW-1:0] a, logic [DW-1:0] b);
    for (int l = 0; l < NL; l++) if (a[l*DL +: DL] !== b[l*DL +: DL]) return l;
    return 0;
  endfunction

  task automatic model_clear();
    full_m = 2'b00; wb_m = 0; rb_m = 0; err_m = 0; exp_valid = 0;
    exp_q.delete(); due_q.delete(); dout_m = '0; p_we = '0;
  endtask

  task automatic idle_inputs();
    wea = '0; wr_done = 0; rd_en = 0; rd_done = 0;
  endtask

  // One clock: the model applies the rules to the inputs present at the edge
  task automatic tick();
    bit wrdy, rrdy;
    logic [DW-1:0] rd;
    wrdy = !full_m[wb_m];
    rrdy = full_m[rb_m];
    @(posedge clk);
    cyc++;
    if (rd_en && rrdy) begin
      for (int l = 0; l < NL; l++) rd[l*DL +: DL] = mem_m[rb_m][l][addrb[l*AL +: AL]];
      exp_q.push_back(rd);
      due_q.push_back(cyc + 1);
    end
    for (int l = 0; l < NL; l++)
      if (p_we[l]) mem_m[p_bank][l][p_addr[l*AL +: AL]] = p_data[l*DL +: DL];
    p_we = wrdy ? wea : '0;
    p_bank = wb_m; p_addr = addra; p_data = dina;
    if (!wrdy && (|wea || wr_done)) err_m = 1;
    if (wr_done && wrdy) begin full_m[wb_m] = 1; wb_m = ~wb_m; end
    if (rd_done && rrdy) begin full_m[rb_m] = 0; rb_m = ~rb_m; end
    #1;
    exp_valid = 0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      exp_valid = 1;
      dout_m = exp_q.pop_front();
      void'(due_q.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; idle_inputs(); model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Write random data to every address of the current write bank
  task automatic fill_bank();
    for (int a = 0; a < DEPTH; a++) begin
      wea = '1;
      for (int l = 0; l < NL; l++) begin
        addra[l*AL +: AL] = AL'(a);
        dina[l*DL +: DL] = $urandom;
      end
      tick();
    end
    wea = '0;
  endtask

  task automatic set_addrb(int a);
    for (int l = 0; l < NL; l++) addrb[l*AL +: AL] = AL'(a);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready); end
    if (wr_bank !== 1'b0) begin errors++; $display("FAIL reset_wr_bank got %b exp 0", wr_bank); end
    if (rd_bank !== 1'b0) begin errors++; $display("FAIL reset_rd_bank got %b exp 0", rd_bank); end
    if (doutb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", doutb_valid); end
    if (doutb !== '0) begin errors++; $display("FAIL reset_doutb lane %0d got %h exp 0", diff_lane(doutb, '0), doutb[diff_lane(doutb, '0)*DL +: DL]); end
    if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %b exp 0", wr_err); end
  endtask

  task automatic test_basic();
    logic [DL-1:0] l0, l63;
    fill_bank();
    wea[0] = 1; wea[63] = 1;
    addra[0*AL +: AL] = 4'd5; addra[63*AL +: AL] = 4'd5;
    dina[0*DL +: DL] = 32'hDEADBEEF; dina[63*DL +: DL] = 32'h12345678;
    tick();
    wea = '0; wr_done = 1;
    tick();
    wr_done = 0;
    checks += 2;
    if (rd_ready !== 1'b1) begin errors++; $display("FAIL basic_rd_ready got %b exp 1", rd_ready); end
    if (wr_bank !== 1'b1) begin errors++; $display("FAIL basic_wr_bank got %b exp 1", wr_bank); end
    rd_en = 1; set_addrb(5);
    tick();
    rd_en = 0;
    checks++;
    if (doutb_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", doutb_valid); end
    tick();
    l0 = doutb[0*DL +: DL]; l63 = doutb[63*DL +: DL];
    checks += 4;
    if (doutb_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", doutb_valid); end
    if (l0 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_lane0 got %h exp deadbeef", l0); end
    if (l63 !== 32'h12345678) begin errors++; $display("FAIL basic_lane63 got %h exp 12345678", l63); end
    if (doutb !== dout_m) begin errors++; $display("FAIL basic_all lane %0d got %h exp %h", diff_lane(doutb, dout_m), doutb[diff_lane(doutb, dout_m)*DL +: DL], dout_m[diff_lane(doutb, dout_m)*DL +: DL]); end
    tick();
    checks++;
    if (doutb_valid !== 1'b0) begin errors++; $display("FAIL basic_single_pulse got %b exp 0", doutb_valid); end
  endtask

  task automatic test_full_err();
    fill_bank();
    wr_done = 1;
    tick();
    wr_done = 0;
    checks += 2;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %b exp 0", wr_ready); end
    if (wr_err !== 1'b0) begin errors++; $display("FAIL full_err_early got %b exp 0", wr_err); end
    wea = NL'({$urandom, $urandom}); wea[0] = 1;
    for (int l = 0; l < NL; l++) begin addra[l*AL +: AL] = 4'd5; dina[l*DL +: DL] = $urandom; end
    tick();
    wea = '0;
    checks++;
    if (wr_err !== 1'b1) begin errors++; $display("FAIL full_wr_err got %b exp 1", wr_err); end
    rd_en = 1; set_addrb(5);
    tick(); rd_en = 0; tick();
    checks += 2;
    if (doutb[0 +: DL] !== 32'hDEADBEEF) begin errors++; $display("FAIL full_bank0_kept got %h exp deadbeef", doutb[0 +: DL]); end
    if (doutb !== dout_m) begin errors++; $display("FAIL full_readback lane %0d got %h exp %h", diff_lane(doutb, dout_m), doutb[diff_lane(doutb, dout_m)*DL +: DL], dout_m[diff_lane(doutb, dout_m)*DL +: DL]); end
  endtask

  task automatic test_back_to_back();
    bit ev;
    for (int k = 0; k < 11; k++) begin
      rd_en = (k < 8); set_addrb(k % DEPTH);
      tick();
      ev = (k >= 1 && k <= 8);
      checks += 3;
      if (doutb_valid !== ev) begin errors++; $display("FAIL stream_valid k=%0d got %b exp %b", k, doutb_valid, ev); end
      if (doutb_valid !== exp_valid) begin errors++; $display("FAIL stream_model_valid k=%0d got %b exp %b", k, doutb_valid, exp_valid); end
      if (doutb !== dout_m) begin errors++; $display("FAIL stream_data k=%0d lane %0d got %h exp %h", k, diff_lane(doutb, dout_m), doutb[diff_lane(doutb, dout_m)*DL +: DL], dout_m[diff_lane(doutb, dout_m)*DL +: DL]); end
    end
    rd_en = 0;
  endtask

  task automatic test_simul_done();
    do_reset();
    fill_bank();
    wr_done = 1; tick(); wr_done = 0;
    for (int k = 0; k < 3; k++) begin
      wea = NL'({$urandom, $urandom});
      for (int l = 0; l < NL; l++) begin addra[l*AL +: AL] = AL'($urandom); dina[l*DL +: DL] = $urandom; end
      tick();
    end
    wea = '0; wr_done = 1; rd_done = 1;
    tick();
    wr_done = 0; rd_done = 0;
    checks += 4;
    if (rd_bank !== 1'b1) begin errors++; $display("FAIL simul_rd_bank got %b exp 1", rd_bank); end
    if (wr_bank !== 1'b0) begin errors++; $display("FAIL simul_wr_bank got %b exp 0", wr_bank); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL simul_wr_ready got %b exp 1", wr_ready); end
    if (rd_ready !== 1'b1) begin errors++; $display("FAIL simul_rd_ready got %b exp 1", rd_ready); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int l = 0; l < NL; l++) begin
        wea[l] = ($urandom_range(0, 3) == 0);
        addra[l*AL +: AL] = AL'($urandom); addrb[l*AL +: AL] = AL'($urandom);
        dina[l*DL +: DL] = $urandom;
      end
      wr_done = ($urandom_range(0, 11) == 0);
      rd_done = ($urandom_range(0, 9) == 0);
      rd_en   = ($urandom_range(0, 1) == 0);
      tick();
      checks += 7;
      if (wr_ready !== !full_m[wb_m]) begin errors++; $display("FAIL rand_wr_ready c=%0d got %b exp %b", cyc, wr_ready, !full_m[wb_m]); end
      if (rd_ready !== full_m[rb_m]) begin errors++; $display("FAIL rand_rd_ready c=%0d got %b exp %b", cyc, rd_ready, full_m[rb_m]); end
      if (wr_bank !== wb_m) begin errors++; $display("FAIL rand_wr_bank c=%0d got %b exp %b", cyc, wr_bank, wb_m); end
      if (rd_bank !== rb_m) begin errors++; $display("FAIL rand_rd_bank c=%0d got %b exp %b", cyc, rd_bank, rb_m); end
      if (wr_err !== err_m) begin errors++; $display("FAIL rand_wr_err c=%0d got %b exp %b", cyc, wr_err, err_m); end
      if (doutb_valid !== exp_valid) begin errors++; $display("FAIL rand_valid c=%0d got %b exp %b", cyc, doutb_valid, exp_valid); end
      if (doutb !== dout_m) begin errors++; $display("FAIL rand_doutb c=%0d lane %0d got %h exp %h", cyc, diff_lane(doutb, dout_m), doutb[diff_lane(doutb, dout_m)*DL +: DL], dout_m[diff_lane(doutb, dout_m)*DL +: DL]); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    do_reset();
    fill_bank();
    wr_done = 1; tick(); wr_done = 0;
    rd_en = 1; set_addrb(3); tick(); rd_en = 0;
    @(negedge clk);
    rst_n = 0; model_clear();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (doutb_valid !== 1'b0) begin errors++; $display("FAIL midop_valid_in_reset got %b exp 0", doutb_valid); end
    end
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks += 4;
      if (doutb_valid !== 1'b0) begin errors++; $display("FAIL midop_valid got %b exp 0", doutb_valid); end
      if (rd_ready !== 1'b0) begin errors++; $display("FAIL midop_rd_ready got %b exp 0", rd_ready); end
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL midop_wr_ready got %b exp 1", wr_ready); end
      if (doutb !== '0) begin errors++; $display("FAIL midop_doutb lane %0d got %h exp 0", diff_lane(doutb, '0), doutb[diff_lane(doutb, '0)*DL +: DL]); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_full_err();
    test_back_to_back();
    test_simul_done();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/buffer_pool_pingpong.md
Name: buffer_pool_pingpong

Overview:
- Parametrised successor to the flat X_MAC x X_MESH buffer pool.
- Every buffer lane is split into two banks (ping/pong). A producer fills one bank set while the MAC array reads the other.
- Banks swap under a fill/drain handshake, and read data carries a valid strobe.
- Sits between the DMA/loader and the MAC mesh; all lanes share one bank pointer pair.

Parameters:
- X_MAC, 4, kernels per mesh port
- X_MESH, 16, mesh ports
- ADDR_LEN, 13, per-bank address width (bank depth 2**ADDR_LEN)
- DATA_LEN, 32, lane data width
- BUFFER_NUM, X_MAC*X_MESH, lane count
- DATAWIDTH, BUFFER_NUM*DATA_LEN, packed data width
- ADDRWIDTH, BUFFER_NUM*ADDR_LEN, packed address width

Ports:
- clk  in  1  single clock, all logic posedge
- rst_n  in  1  asynchronous active-low reset
- dina  in  DATAWIDTH  write data; lane i at [i*DATA_LEN +: DATA_LEN], i = kernel + port*X_MAC
- addra  in  ADDRWIDTH  per-lane write address within the write bank
- wea  in  BUFFER_NUM  per-lane write enable
- wr_done  in  1  producer finished filling the current write bank
- wr_ready  out  1  write bank is empty and writable
- addrb  in  ADDRWIDTH  per-lane read address within the read bank
- rd_en  in  1  read request, all lanes
- rd_done  in  1  consumer finished with the current read bank
- rd_ready  out  1  read bank is full and readable
- doutb  out  DATAWIDTH  read data, same lane packing as dina
- doutb_valid  out  1  doutb holds data for the rd_en issued 2 cycles earlier
- wr_bank  out  1  current write bank pointer
- rd_bank  out  1  current read bank pointer
- wr_err  out  1  sticky: write or wr_done attempted while wr_ready=0

Behaviour:
- Storage: per lane, one simple-dual-port RAM of depth 2*2**ADDR_LEN. Physical address = {bank bit, lane address}.
- Bank state: full[1:0] and pointers wr_bank/rd_bank.
  - Reset values: full=2'b00, wr_bank=0, rd_bank=0, wr_err=0, doutb_valid=0, doutb=0.
  - Reset gives wr_ready=1, rd_ready=0.
- wr_ready = ~full[wr_bank]; rd_ready = full[rd_bank]. Both are combinational from registers.
- Write path:
  - dina, addra, wea and wr_done are registered one cycle (stage W1).
  - The RAM write happens in W1 using the wr_bank value sampled at input time.
  - A write accepted in cycle N is visible to a read issued in cycle N+2 or later.
- Write gating:
  - wea bits while wr_ready=0 are dropped and set wr_err.
  - wr_done while wr_ready=0 is ignored and sets wr_err.
  - wr_err clears only on reset.
- Fill handshake: wr_done sampled with wr_ready=1 in cycle N gives, at edge N+1:
  - full[wr_bank] set and wr_bank toggled;
  - writes presented in cycle N still land in the old bank (same W1 stage).
  - Writes in cycle N+1 target the new bank, gated by its wr_ready.
- Drain handshake: rd_done sampled with rd_ready=1 gives, next edge:
  - full[rd_bank] cleared and rd_bank toggled.
  - rd_done with rd_ready=0 is ignored.
- Simultaneous wr_done and rd_done:
  - Both take effect the same edge; they always address different bank states, so no conflict.
  - A bank cleared by rd_done in cycle N is writable, with wr_ready=1, from cycle N+1.
- Read path:
  - rd_en sampled with rd_ready=1 in cycle N: RAM read uses {rd_bank, addrb}. With the RAM registered output plus the output register, doutb is valid at cycle N+2 and doutb_valid=1 for one cycle per accepted rd_en.
  - rd_en with rd_ready=0: no valid generated, and doutb holds its prior value.
  - Back-to-back rd_en gives one result per cycle, fully pipelined.
  - rd_en and rd_done in the same cycle: the read uses the old bank and still returns valid data at N+2.
- Both banks full: wr_ready=0 until a drain. Both empty: rd_ready=0.
- Reset mid-operation:
  - All control registers and the valid pipeline clear asynchronously; in-flight reads are discarded.
  - RAM contents are not cleared, and banks are treated as empty.

Test Plan:
- Reset then idle -> wr_ready=1, rd_ready=0, wr_bank=0, rd_bank=0, doutb_valid=0, doutb=0.
- Lane 0 writes addr 5 = 0xDEADBEEF and lane 63 writes addr 5 = 0x12345678, then wr_done -> rd_ready=1, wr_bank=1. rd_en with addrb=5 on all lanes -> 2 cycles later doutb_valid=1 and lanes 0/63 read those values.
- Fill bank 0 (wr_done), fill bank 1 (wr_done), then assert wea -> wr_ready=0, wr_err=1, and bank 0 data unchanged on readback.
- Streaming rd_en for 8 cycles, addr 0..7 -> doutb_valid high for 8 consecutive cycles starting 2 cycles after the first rd_en, data in order.
- rd_done and wr_done in the same cycle with bank 0 full/read and bank 1 being filled -> next cycle rd_bank=1, wr_bank=0, full=2'b10, wr_ready=1, rd_ready=1.
- Assert rst_n=0 one cycle after rd_en -> doutb_valid never pulses; after release, rd_ready=0 and wr_ready=1.
